// File: rtl/data_mem_responder.sv
// Word-organised data memory that answers RV32I loads/stores after a fixed latency.
// One request is in flight at a time; responses are held until rsp_ready.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        perform;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          range_ok;
  logic          align_ok;
  logic          f3_ok;
  logic          acc_err;
  logic [31:0]   mem_word;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_data;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;

  assign idx = addr_q[AW+1:2];

  // Access decode works on the captured request so late input changes cannot leak in.
  always_comb begin
    range_ok  = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    align_ok  = 1'b0;
    f3_ok     = 1'b0;
    wr_be     = '0;
    wr_word   = '0;
    load_data = '0;
    mem_word  = mem_q[idx];
    byte_lane = mem_word[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

    case (f3_q[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~addr_q[0];
      2'b10:   align_ok = (addr_q[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase

    if (we_q) f3_ok = (f3_q == 3'd0) || (f3_q == 3'd1) || (f3_q == 3'd2);
    else      f3_ok = (f3_q != 3'd3) && (f3_q != 3'd6) && (f3_q != 3'd7);

    acc_err = ~(range_ok & align_ok & f3_ok);

    case (f3_q)
      3'd0:    load_data = {{24{byte_lane[7]}}, byte_lane};
      3'd1:    load_data = {{16{half_lane[15]}}, half_lane};
      3'd2:    load_data = mem_word;
      3'd4:    load_data = {24'd0, byte_lane};
      3'd5:    load_data = {16'd0, half_lane};
      default: load_data = '0;
    endcase

    case (f3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_word = wdata_q;
      end
      default: begin
        wr_be   = '0;
        wr_word = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    perform = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          perform = 1'b1;
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? '0 : load_data;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory is deliberately not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset && perform && we_q && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
